// File: rtl/video_out_pkg.sv
// Shared types and tint gain table for the monochrome-to-RGB video stage.
package video_out_pkg;

   localparam int GAIN_W = 8;

   typedef enum logic [2:0] {
      WHITE  = 3'd0,
      RED    = 3'd1,
      GREEN  = 3'd2,
      BLUE   = 3'd3,
      AMBER  = 3'd4,
      CUSTOM = 3'd5
   } tint_t;

   typedef enum logic [1:0] {
      DIM_OFF = 2'd0,
      DIM_25  = 2'd1,
      DIM_50  = 2'd2,
      DIM_75  = 2'd3
   } dim_t;

   // {R,G,B} gains; the CUSTOM slot is replaced by the shadow gains
   localparam logic [3*GAIN_W-1:0] TINT_GAIN [0:5] = '{
      24'hFFFFFF,
      24'hFF0000,
      24'h00FF00,
      24'h0000FF,
      24'hFFBF00,
      24'hFFFFFF
   };

   function automatic tint_t to_tint(logic [2:0] t);
      return (t > 3'd5) ? WHITE : tint_t'(t);
   endfunction

endpackage

// File: rtl/video_tint_stage_if.sv
// Pixel/timing/mode inputs and RGB/sync outputs of the video tint stage.
interface video_tint_if
   import video_out_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
);
   logic              ce_pix;
   logic [IN_W-1:0]   pix;
   logic              hblank;
   logic              vblank;
   logic              hsync;
   logic              vsync;
   logic [2:0]        tint;
   logic [GAIN_W-1:0] gain_r;
   logic [GAIN_W-1:0] gain_g;
   logic [GAIN_W-1:0] gain_b;
   logic [1:0]        dim;
   logic [OUT_W-1:0]  r_out;
   logic [OUT_W-1:0]  g_out;
   logic [OUT_W-1:0]  b_out;
   logic              hs_out;
   logic              vs_out;
   logic              de_out;

   modport master (
      output ce_pix, pix, hblank, vblank, hsync, vsync,
      output tint, gain_r, gain_g, gain_b, dim,
      input  r_out, g_out, b_out, hs_out, vs_out, de_out
   );

   modport slave (
      input  ce_pix, pix, hblank, vblank, hsync, vsync,
      input  tint, gain_r, gain_g, gain_b, dim,
      output r_out, g_out, b_out, hs_out, vs_out, de_out
   );
endinterface

// File: rtl/tint_gain.sv
// One colour channel: widen intensity by bit replication, then scale by gain.
module tint_gain
   import video_out_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
) (
   input  logic [IN_W-1:0]   pix,
   input  logic [GAIN_W-1:0] gain,
   output logic [OUT_W-1:0]  ch
);

   logic [OUT_W-1:0] x;
   logic [OUT_W+8:0] prod;
   logic             unused_bits;

   always_comb begin
      x = '0;
      for (int i = 0; i < OUT_W; i++) begin
         x[OUT_W-1-i] = pix[IN_W-1-(i % IN_W)];
      end
   end

   assign prod = {9'd0, x} * ({{(OUT_W+1){1'b0}}, gain} + 1'b1);

   // gain 0 must give a hard zero rather than x>>8
   assign ch = (gain == '0) ? '0 : prod[OUT_W+7:8];

   assign unused_bits = ^{prod[7:0], prod[OUT_W+8]};

endmodule

// File: rtl/video_tint_stage.sv
// Two-stage mono-to-RGB output: gain/tint, then scanline dim and blanking.
module video_tint_stage
   import video_out_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
) (
   input logic        clk,
   input logic        reset_n,
   video_tint_if.slave vid
);

   tint_t             sh_tint;
   logic [GAIN_W-1:0] sh_gr;
   logic [GAIN_W-1:0] sh_gg;
   logic [GAIN_W-1:0] sh_gb;
   dim_t              sh_dim;

   logic hs_prev;
   logic vs_prev;
   logic parity;
   logic parity_nxt;
   logic hs_rise;
   logic vs_rise;

   logic [GAIN_W-1:0] g_r;
   logic [GAIN_W-1:0] g_g;
   logic [GAIN_W-1:0] g_b;
   logic [OUT_W-1:0]  m_r;
   logic [OUT_W-1:0]  m_g;
   logic [OUT_W-1:0]  m_b;

   logic [OUT_W-1:0] s1_r;
   logic [OUT_W-1:0] s1_g;
   logic [OUT_W-1:0] s1_b;
   logic             s1_hs;
   logic             s1_vs;
   logic             s1_de;
   logic             s1_par;

   assign hs_rise = vid.ce_pix & vid.hsync & ~hs_prev;
   assign vs_rise = vid.ce_pix & vid.vsync & ~vs_prev;

   always_comb begin
      parity_nxt = parity;
      if (vs_rise)      parity_nxt = 1'b0;
      else if (hs_rise) parity_nxt = ~parity;
   end

   always_comb begin
      {g_r, g_g, g_b} = TINT_GAIN[sh_tint];
      if (sh_tint == CUSTOM) begin
         g_r = sh_gr;
         g_g = sh_gg;
         g_b = sh_gb;
      end
   end

   tint_gain #(.IN_W(IN_W), .OUT_W(OUT_W)) u_gain_r (
      .pix (vid.pix),
      .gain(g_r),
      .ch  (m_r)
   );

   tint_gain #(.IN_W(IN_W), .OUT_W(OUT_W)) u_gain_g (
      .pix (vid.pix),
      .gain(g_g),
      .ch  (m_g)
   );

   tint_gain #(.IN_W(IN_W), .OUT_W(OUT_W)) u_gain_b (
      .pix (vid.pix),
      .gain(g_b),
      .ch  (m_b)
   );

   function automatic logic [OUT_W-1:0] dim_ch(
      logic [OUT_W-1:0] c,
      dim_t             d,
      logic             odd,
      logic             de
   );
      logic [OUT_W-1:0] y;
      y = c;
      if (odd) begin
         case (d)
            DIM_25:  y = c - (c >> 2);
            DIM_50:  y = c - (c >> 1);
            DIM_75:  y = c >> 2;
            default: y = c;
         endcase
      end
      if (!de) y = '0;
      return y;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_tint    <= WHITE;
         sh_gr      <= '1;
         sh_gg      <= '1;
         sh_gb      <= '1;
         sh_dim     <= DIM_OFF;
         hs_prev    <= 1'b0;
         vs_prev    <= 1'b0;
         parity     <= 1'b0;
         s1_r       <= '0;
         s1_g       <= '0;
         s1_b       <= '0;
         s1_hs      <= 1'b0;
         s1_vs      <= 1'b0;
         s1_de      <= 1'b0;
         s1_par     <= 1'b0;
         vid.r_out  <= '0;
         vid.g_out  <= '0;
         vid.b_out  <= '0;
         vid.hs_out <= 1'b0;
         vid.vs_out <= 1'b0;
         vid.de_out <= 1'b0;
      end else if (vid.ce_pix) begin
         hs_prev <= vid.hsync;
         vs_prev <= vid.vsync;
         parity  <= parity_nxt;
         // pixel entering now uses the old mode; new mode from next pixel
         if (vs_rise) begin
            sh_tint <= to_tint(vid.tint);
            sh_gr   <= vid.gain_r;
            sh_gg   <= vid.gain_g;
            sh_gb   <= vid.gain_b;
            sh_dim  <= dim_t'(vid.dim);
         end
         s1_r   <= m_r;
         s1_g   <= m_g;
         s1_b   <= m_b;
         s1_hs  <= vid.hsync;
         s1_vs  <= vid.vsync;
         s1_de  <= ~(vid.hblank | vid.vblank);
         s1_par <= parity_nxt;
         vid.r_out  <= dim_ch(s1_r, sh_dim, s1_par, s1_de);
         vid.g_out  <= dim_ch(s1_g, sh_dim, s1_par, s1_de);
         vid.b_out  <= dim_ch(s1_b, sh_dim, s1_par, s1_de);
         vid.hs_out <= s1_hs;
         vid.vs_out <= s1_vs;
         vid.de_out <= s1_de;
      end
   end

endmodule

// File: tb/tb_video_tint_stage.sv
// Directed bench for video_tint_stage (8-bit and 4-bit input instances).
module tb_video_tint_stage;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   video_tint_if #(.IN_W(8), .OUT_W(8)) vif ();
   video_tint_if #(.IN_W(4), .OUT_W(8)) vif4 ();

   video_tint_stage #(.IN_W(8), .OUT_W(8)) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .vid    (vif)
   );

   video_tint_stage #(.IN_W(4), .OUT_W(8)) u_dut4 (
      .clk    (clk),
      .reset_n(reset_n),
      .vid    (vif4)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_mode(input logic [2:0] t, input logic [7:0] gr,
                           input logic [7:0] gg, input logic [7:0] gb,
                           input logic [1:0] d);
      vif.tint = t;     vif4.tint = t;
      vif.gain_r = gr;  vif4.gain_r = gr;
      vif.gain_g = gg;  vif4.gain_g = gg;
      vif.gain_b = gb;  vif4.gain_b = gb;
      vif.dim = d;      vif4.dim = d;
   endtask

   // one ce_pix pulse every 4th clk; ends on a negedge
   task automatic step(input logic [7:0] p, input logic hb, input logic vb,
                       input logic hs, input logic vs);
      vif.pix = p;       vif4.pix = p[7:4];
      vif.hblank = hb;   vif4.hblank = hb;
      vif.vblank = vb;   vif4.vblank = vb;
      vif.hsync = hs;    vif4.hsync = hs;
      vif.vsync = vs;    vif4.vsync = vs;
      @(negedge clk);
      vif.ce_pix = 1'b1; vif4.ce_pix = 1'b1;
      @(negedge clk);
      vif.ce_pix = 1'b0; vif4.ce_pix = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [31:0] rgb8();
      return {8'h0, vif.r_out, vif.g_out, vif.b_out};
   endfunction

   task automatic frame();
      step(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      step(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      check("vs_out", {31'd0, vif.vs_out}, 32'd1);
   endtask

   task automatic hline();
      step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pix_chk(input string tag, input logic [7:0] p,
                          input logic [23:0] exp);
      step(p, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check(tag, rgb8(), {8'h0, exp});
   endtask

   initial begin
      vif.ce_pix = 1'b0;  vif4.ce_pix = 1'b0;
      set_mode(3'd0, 8'hFF, 8'hFF, 8'hFF, 2'd0);
      vif.pix = '0; vif4.pix = '0;
      vif.hblank = 1'b1; vif4.hblank = 1'b1;
      vif.vblank = 1'b1; vif4.vblank = 1'b1;
      vif.hsync = 1'b0;  vif4.hsync = 1'b0;
      vif.vsync = 1'b0;  vif4.vsync = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rgb", rgb8(), 32'h0);
      check("rst_sync", {29'd0, vif.hs_out, vif.vs_out, vif.de_out}, 32'h0);
      reset_n = 1'b1;

      // expansion and latency on the 4-bit instance
      frame();
      step(8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lat_1ce", {24'h0, vif4.r_out}, 32'h0);
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("expand4", {8'h0, vif4.r_out, vif4.g_out, vif4.b_out}, 32'hAAAAAA);
      check("white8", rgb8(), 32'hA0A0A0);
      @(negedge clk);
      check("hold", {24'h0, vif4.r_out}, 32'hAA);

      // tints
      set_mode(3'd4, 8'h00, 8'h00, 8'h00, 2'd0);
      frame();
      pix_chk("amber", 8'hFF, 24'hFFBF00);
      set_mode(3'd2, 8'h00, 8'h00, 8'h00, 2'd0);
      frame();
      pix_chk("green", 8'hFF, 24'h00FF00);
      set_mode(3'd5, 8'h7F, 8'h00, 8'hFF, 2'd0);
      frame();
      pix_chk("custom", 8'hFF, 24'h7F00FF);
      set_mode(3'd7, 8'h00, 8'h00, 8'h00, 2'd0);
      frame();
      pix_chk("tint7", 8'hFF, 24'hFFFFFF);

      // mode latched only at vsync
      set_mode(3'd0, 8'hFF, 8'hFF, 8'hFF, 2'd0);
      frame();
      set_mode(3'd1, 8'hFF, 8'hFF, 8'hFF, 2'd0);
      pix_chk("latched", 8'hFF, 24'hFFFFFF);
      frame();
      pix_chk("red", 8'hFF, 24'hFF0000);

      // scanlines
      set_mode(3'd0, 8'hFF, 8'hFF, 8'hFF, 2'd2);
      frame();
      pix_chk("line0", 8'hFF, 24'hFFFFFF);
      hline();
      pix_chk("line1", 8'hFF, 24'h808080);
      hline();
      pix_chk("line2", 8'hFF, 24'hFFFFFF);
      step(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      step(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      pix_chk("coincide", 8'hFF, 24'hFFFFFF);
      set_mode(3'd0, 8'hFF, 8'hFF, 8'hFF, 2'd1);
      frame();
      hline();
      pix_chk("dim25", 8'hFF, 24'hC0C0C0);

      // blanking and DE alignment
      set_mode(3'd0, 8'hFF, 8'hFF, 8'hFF, 2'd0);
      frame();
      step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
      step(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      check("blank_rgb", rgb8(), 32'h0);
      check("blank_hs_de", {30'd0, vif.hs_out, vif.de_out}, 32'h2);
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("de_1ce", {31'd0, vif.de_out}, 32'h0);
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("de_2ce", {23'd0, vif.de_out, vif.r_out}, 32'h1FF);

      // asynchronous reset mid-line with a full pipeline
      set_mode(3'd1, 8'hFF, 8'hFF, 8'hFF, 2'd0);
      frame();
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pre_rst", rgb8(), 32'hFF0000);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_rgb", rgb8(), 32'h0);
      check("rst_mid_sync", {29'd0, vif.hs_out, vif.vs_out, vif.de_out}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("post_rst_1ce", rgb8(), 32'h0);
      step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("post_rst_white", rgb8(), 32'hFFFFFF);
      frame();
      pix_chk("post_rst_red", 8'hFF, 24'hFF0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
